// File: rtl/bcd_display_driver_pkg.sv
// rtl/bcd_display_driver_pkg.sv - shared states, segment patterns and limits for the BCD display driver
package bcd_display_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4
    } state_e;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [13:0] MAX_DISPLAY = 14'd9999;

endpackage

// File: rtl/bcd_display_driver_seg7_decode.sv
// rtl/bcd_display_driver_seg7_decode.sv - combinational BCD to active-low seven-segment decoder
//
// Ports:
//   digit_i  4-bit BCD digit
//   seg_o    7-bit active-low segment pattern (bit 0 = a); codes 10-15 decode to blank
module seg7_decode
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_DIGITS[0];
            4'd1:    seg_o = SEG_DIGITS[1];
            4'd2:    seg_o = SEG_DIGITS[2];
            4'd3:    seg_o = SEG_DIGITS[3];
            4'd4:    seg_o = SEG_DIGITS[4];
            4'd5:    seg_o = SEG_DIGITS[5];
            4'd6:    seg_o = SEG_DIGITS[6];
            4'd7:    seg_o = SEG_DIGITS[7];
            4'd8:    seg_o = SEG_DIGITS[8];
            4'd9:    seg_o = SEG_DIGITS[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - binary to BCD via external divide-by-10 engine, multiplexed 4-digit display
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load, value       one-cycle conversion request with 14-bit binary value
//   busy, err         conversion in progress, sticky fault flag
//   div_start         one-cycle start pulse to the divider
//   div_value         dividend, held from div_start until the digit is stored
//   div_quotient      divider quotient
//   div_remainder     divider remainder (next BCD digit)
//   div_ready         divider done level
//   bcd               committed digits, [3:0] = ones
//   an, seg, dp       active-low digit enables, segments and decimal point
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int SCAN_BITS     = 16,
    parameter int BLANK_LEADING = 1,
    parameter int TIMEOUT       = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value,
    output logic        busy,
    output logic        err,
    output logic        div_start,
    output logic [13:0] div_value,
    input  logic [9:0]  div_quotient,
    input  logic [3:0]  div_remainder,
    input  logic        div_ready,
    output logic [15:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [5:0] TMO_LIMIT = 6'(TIMEOUT);

    state_e         state_q, state_d;
    logic [13:0]    work_q, work_d;
    logic [1:0]     d_q, d_d;
    logic [5:0]     tmo_q, tmo_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    bcd_q, bcd_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;

    logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;

    logic [3:0]     digit_sel;
    logic [15:0]    upper_digits;
    logic           lead_blank;
    logic [6:0]     digit_seg;

    // Conversion FSM
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        d_d       = d_q;
        tmo_d     = tmo_q;
        shadow_d  = shadow_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    err_d = 1'b0;
                    if (value <= MAX_DISPLAY) begin
                        work_d  = value;
                        d_d     = 2'd0;
                        state_d = ST_START;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                div_start = 1'b1;
                tmo_d     = 6'd0;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                // div_ready may still be high from the previous division.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    state_d = ST_STORE;
                end else begin
                    tmo_d = tmo_q + 6'd1;
                    if (tmo_d == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STORE: begin
                if (div_remainder > 4'd9) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shadow_d[{d_q, 2'b00} +: 4] = div_remainder;
                    work_d = {4'b0, div_quotient};
                    if (d_q == 2'd3) begin
                        // Last digit lands in the same edge as the commit.
                        bcd_d   = shadow_d;
                        ovf_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        d_d     = d_q + 2'd1;
                        state_d = ST_START;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= 14'd0;
            d_q      <= 2'd0;
            tmo_q    <= 6'd0;
            shadow_q <= 16'd0;
            bcd_q    <= 16'd0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            d_q      <= d_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    // Display scanner: an/seg are computed from the next index so they move together with it.
    always_comb begin
        scan_cnt_d   = scan_cnt_q + 1'b1;
        idx_d        = (&scan_cnt_q) ? idx_q + 2'd1 : idx_q;
        an_d         = ~(4'b0001 << idx_d);
        digit_sel    = bcd_q[{idx_d, 2'b00} +: 4];
        upper_digits = bcd_q >> {idx_d, 2'b00};
        lead_blank   = (BLANK_LEADING != 0) && (idx_d != 2'd0) && (upper_digits == 16'd0);
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (lead_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = digit_seg;
        end
    end

    seg7_decode u_seg7_decode (
        .digit_i (digit_sel),
        .seg_o   (digit_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= SEG_DIGITS[0];
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign div_value = work_q;
    assign bcd       = bcd_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - scoreboard bench for bcd_display_driver with behavioural divider
module tb_bcd_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = 14'd0;
    logic        busy, err, div_start, dp;
    logic [13:0] div_value;
    logic [9:0]  div_quotient;
    logic [3:0]  div_remainder;
    logic        div_ready = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_display_driver #(
        .SCAN_BITS     (2),
        .BLANK_LEADING (1),
        .TIMEOUT       (63)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .value         (value),
        .busy          (busy),
        .err           (err),
        .div_start     (div_start),
        .div_value     (div_value),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_ready     (div_ready),
        .bcd           (bcd),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    // Behavioural divider: ready rises L edges after the edge that sees div_start.
    int          lat = 14;
    bit          no_ready = 1'b0;
    int          bad_div = -1;
    logic [13:0] dv = 14'd0;
    int          cnt = 0;

    always @(posedge clk) begin
        if (div_start) begin
            dv        <= div_value;
            cnt       <= lat;
            div_ready <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !no_ready) div_ready <= 1'b1;
        end
    end

    assign div_quotient  = 10'(dv / 14'd10);
    assign div_remainder = (int'(dv) == bad_div) ? 4'hC : 4'(dv % 14'd10);

    // Reference model
    int p10[4] = '{1, 10, 100, 1000};
    int shown_val = 0;
    bit shown_ovf = 1'b0;

    logic [13:0] exp_div[$];
    logic [15:0] exp_bcd[$];
    bit          exp_err[$];

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = 16'd0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / p10[i]) % 10);
        return r;
    endfunction

    function automatic logic [6:0] digit_pat(int dgt);
        case (dgt)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int v, bit ovf, int idx);
        if (ovf) return 7'b0111111;
        if (idx > 0 && v < p10[idx]) return 7'b1111111;
        return digit_pat((v / p10[idx]) % 10);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: div_start pulses and busy falling edges pop the scoreboard.
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (div_start) begin
                if (exp_div.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_div_start: got div_value %0d expected no pulse", div_value);
                end else begin
                    chk("div_value", 32'(div_value), 32'(exp_div.pop_front()));
                end
            end
            if (prev_busy && !busy) begin
                if (exp_bcd.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: got bcd %0h expected no completion", bcd);
                end else begin
                    chk("done_bcd", 32'(bcd), 32'(exp_bcd.pop_front()));
                    chk("done_err", 32'(err), 32'(exp_err.pop_front()));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int v);
        load  = 1'b1;
        value = 14'(v);
        tick();
        load  = 1'b0;
    endtask

    task automatic do_load_valid(int v);
        for (int i = 0; i < 4; i++) exp_div.push_back(14'(v / p10[i]));
        exp_bcd.push_back(to_bcd(v));
        exp_err.push_back(1'b0);
        do_load(v);
    endtask

    // Cycles from the current (START) cycle until busy is seen low.
    task automatic wait_idle(string name, int budget, output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, budget);
        end
    endtask

    task automatic scan_check(string name);
        int idx;
        repeat (2) tick();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                n_chk++; n_err++;
                $display("FAIL %s_an: got %b expected one-hot-low", name, an);
            end else begin
                chk($sformatf("%s_seg%0d", name, idx), 32'(seg), 32'(exp_seg(shown_val, shown_ovf, idx)));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(7'b1000000));
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_div_value", 32'(div_value), 0);
        chk("rst_dp", 32'(dp), 1);
        scan_check("rst_scan");

        // 1234 with L=14: 17 cycles per digit
        lat = 14;
        tick();
        do_load_valid(1234);
        wait_idle("lat1234", 200, n);
        chk("lat1234", 32'(n), 68);
        shown_val = 1234; shown_ovf = 1'b0;
        scan_check("s1234");

        // 7 then overflow
        lat = 2;
        tick();
        do_load_valid(7);
        wait_idle("v7", 100, n);
        shown_val = 7;
        scan_check("s7");
        do_load(10000);
        @(negedge clk);
        chk("ovf_busy", 32'(busy), 0);
        shown_ovf = 1'b1;
        scan_check("sovf");
        chk("ovf_bcd", 32'(bcd), 32'(16'h0007));

        // 9999 with an ignored second load
        lat = 3;
        tick();
        do_load_valid(9999);
        repeat (10) tick();
        load = 1'b1; value = 14'd1111;
        tick();
        load = 1'b0;
        wait_idle("v9999", 100, n);
        shown_val = 9999; shown_ovf = 1'b0;
        scan_check("s9999");

        // Reset during WAIT, with load held across the reset edges
        lat = 14;
        tick();
        do_load_valid(5678);
        repeat (3) tick();
        exp_div.delete(); exp_bcd.delete(); exp_err.delete();
        rst = 1'b1; load = 1'b1; value = 14'd1111;
        repeat (2) tick();
        load = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_bcd", 32'(bcd), 0);
        chk("rst2_an", 32'(an), 32'(4'b1110));
        chk("rst2_seg", 32'(seg), 32'(7'b1000000));
        shown_val = 0;
        repeat (100) tick();
        chk("rst2_idle", 32'(busy), 0);

        // Divider never ready: abort after 63 WAIT cycles
        no_ready = 1'b1;
        exp_div.push_back(14'd42);
        exp_bcd.push_back(to_bcd(shown_val));
        exp_err.push_back(1'b1);
        do_load(42);
        wait_idle("tmo", 200, n);
        chk("tmo_cycles", 32'(n), 65);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_bcd", 32'(bcd), 0);
        no_ready = 1'b0;
        tick();
        do_load_valid(42);
        chk("err_clear", 32'(err), 0);
        wait_idle("v42", 100, n);
        shown_val = 42;

        // Bad remainder on digit 2
        lat = 2;
        bad_div = 34;
        exp_div.push_back(14'd3456);
        exp_div.push_back(14'd345);
        exp_div.push_back(14'd34);
        exp_bcd.push_back(to_bcd(shown_val));
        exp_err.push_back(1'b1);
        tick();
        do_load(3456);
        wait_idle("badrem", 100, n);
        chk("badrem_err", 32'(err), 1);
        bad_div = -1;
        scan_check("sbad");

        // Randomized conversions
        for (int it = 0; it < 12; it++) begin
            lat = $urandom_range(1, 6);
            tick();
            if ($urandom_range(0, 5) == 0) begin
                v = 10000 + $urandom_range(0, 6383);
                do_load(v);
                @(negedge clk);
                chk("rnd_ovf_busy", 32'(busy), 0);
                chk("rnd_ovf_bcd", 32'(bcd), 32'(to_bcd(shown_val)));
                shown_ovf = 1'b1;
            end else begin
                v = $urandom_range(0, 9999);
                do_load_valid(v);
                wait_idle("rnd", 100, n);
                chk("rnd_lat", 32'(n), 32'(4 * (lat + 3)));
                shown_val = v;
                shown_ovf = 1'b0;
            end
            scan_check("srnd");
        end

        repeat (4) tick();
        chk("drain_div", 32'(exp_div.size()), 0);
        chk("drain_res", 32'(exp_bcd.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
